// File: rtl/bnn_layer_sequencer.sv
// Two-layer binary neural network sequencer: one shared XNOR-popcount/threshold
// unit evaluates one neuron per enabled cycle, first layer 1 (from x), then layer 2 (from h).
module bnn_layer_sequencer #(
  parameter int unsigned THRESH = 6,
  parameter int unsigned N_L1   = 8,
  parameter int unsigned N_L2   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [7:0]        x_in,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic [N_L2-1:0]   y_out,
  output logic [N_L1-1:0]   h_out
);

  localparam int unsigned NW  = N_L1 + N_L2;
  localparam int unsigned L1W = $clog2(N_L1);
  localparam int unsigned L2W = $clog2(N_L2);

  typedef enum logic [1:0] {
    IDLE,
    L1,
    L2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        x_q, x_d;
  logic [N_L1-1:0]   h_q, h_d;
  logic [N_L2-1:0]   y_acc_q, y_acc_d;
  logic [N_L2-1:0]   y_q, y_d;
  logic [7:0]        w_q [NW];
  logic [7:0]        w_d [NW];

  logic [3:0]        w_sel;
  logic [7:0]        a_op;
  logic [7:0]        w_op;
  logic [7:0]        match;
  logic [3:0]        pop;
  logic              fire;

  function automatic logic [7:0] w_reset(input int unsigned n);
    case (n)
      0:       w_reset = 8'hA0;
      1:       w_reset = 8'h41;
      2:       w_reset = 8'h7A;
      3:       w_reset = 8'h18;
      4:       w_reset = 8'hED;
      5:       w_reset = 8'hB7;
      6:       w_reset = 8'h67;
      7:       w_reset = 8'h3A;
      8:       w_reset = 8'hF9;
      9:       w_reset = 8'h62;
      10:      w_reset = 8'hF7;
      11:      w_reset = 8'h0F;
      default: w_reset = 8'h00;
    endcase
  endfunction

  // Shared neuron unit: layer-2 neurons live after the layer-1 weights.
  always_comb begin
    w_sel = (state_q == L2) ? (idx_q + 4'(N_L1)) : idx_q;
    a_op  = (state_q == L2) ? 8'(h_q) : x_q;
    w_op  = w_q[w_sel];
    match = ~(a_op ^ w_op);
    pop   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      pop = pop + 4'(match[i]);
    end
    fire = (pop >= 4'(THRESH));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    x_d     = x_q;
    h_d     = h_q;
    y_acc_d = y_acc_q;
    y_d     = y_q;
    w_d     = w_q;

    if (ena) begin
      if (wr_en && !busy_q && (32'(wr_addr) < NW)) begin
        w_d[wr_addr] = wr_data;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            x_d     = x_in;
            idx_d   = '0;
            busy_d  = 1'b1;
            y_acc_d = '0;
            state_d = L1;
          end
        end
        L1: begin
          h_d[idx_q[L1W-1:0]] = fire;
          if (idx_q == 4'(N_L1 - 1)) begin
            idx_d   = '0;
            state_d = L2;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        L2: begin
          y_acc_d[idx_q[L2W-1:0]] = fire;
          if (idx_q == 4'(N_L2 - 1)) begin
            // Result includes the neuron evaluated on this same edge.
            y_d     = y_acc_d;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      x_q     <= '0;
      h_q     <= '0;
      y_acc_q <= '0;
      y_q     <= '0;
      for (int unsigned i = 0; i < NW; i++) begin
        w_q[i] <= w_reset(i);
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      x_q     <= x_d;
      h_q     <= h_d;
      y_acc_q <= y_acc_d;
      y_q     <= y_d;
      w_q     <= w_d;
    end
  end

  assign wr_ready = ~busy_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign y_out    = y_q;
  assign h_out    = h_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Directed bench for bnn_layer_sequencer with hand-computed expected activations.
module tb_bnn_layer_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] x_in;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic [3:0] y_out;
  logic [7:0] h_out;

  int checks = 0;
  int errors = 0;

  bnn_layer_sequencer #(.THRESH(6), .N_L1(8), .N_L2(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .x_in     (x_in),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .y_out    (y_out),
    .h_out    (h_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One inference with optional disturbances at loop tick indices (1000 = none).
  task automatic run(input logic [7:0] x, input int ena_off_at, input int noise_at,
                     input int rst_at, output int lat, output int busy_cyc,
                     output int dones, output logic [7:0] h_s, output logic [3:0] y_s);
    lat = 0; busy_cyc = 0; dones = 0; h_s = '0; y_s = '0;
    x_in  = x;
    start = 1'b1;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_wr_ready", 32'(wr_ready), 32'd0);
    if (busy) busy_cyc++;
    for (int t = 1; t <= 30; t++) begin
      ena = !(t >= ena_off_at && t < ena_off_at + 5);
      if (t >= noise_at && t < noise_at + 3) begin
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hFF; start = 1'b1;
      end else begin
        wr_en = 1'b0; start = 1'b0;
      end
      if (t == rst_at) begin
        rst_n = 1'b0;
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_y", 32'(y_out), 32'd0);
        check("rst_h", 32'(h_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        #1;
      end
      tick();
      if (busy) busy_cyc++;
      if (done) begin
        dones++;
        if (lat == 0) begin
          lat = t; h_s = h_out; y_s = y_out;
        end
      end
    end
    ena = 1'b1; wr_en = 1'b0; start = 1'b0;
  endtask

  int         lat, bc, dn, n;
  logic [7:0] hs;
  logic [3:0] ys;

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; x_in = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_y", 32'(y_out), 32'd0);
    check("reset_h", 32'(h_out), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // x=00 with default weights
    run(8'h00, 1000, 1000, 1000, lat, bc, dn, hs, ys);
    check("x00_lat", 32'(lat), 32'd12);
    check("x00_busy_cycles", 32'(bc), 32'd12);
    check("x00_dones", 32'(dn), 32'd1);
    check("x00_h", 32'(hs), 32'h0B);
    check("x00_y", 32'(ys), 32'h8);

    // x=FF with default weights
    run(8'hFF, 1000, 1000, 1000, lat, bc, dn, hs, ys);
    check("xff_lat", 32'(lat), 32'd12);
    check("xff_busy_cycles", 32'(bc), 32'd12);
    check("xff_dones", 32'(dn), 32'd1);
    check("xff_h", 32'(hs), 32'h30);
    check("xff_y", 32'(ys), 32'h0);
    check("xff_y_held", 32'(y_out), 32'h0);

    // back-to-back: start asserted in the done cycle
    x_in = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("b2b_first_lat", 32'(n), 32'd12);
    check("b2b_first_y", 32'(y_out), 32'h8);
    x_in = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_second_accept", 32'(busy), 32'd1);
    check("b2b_done_cleared", 32'(done), 32'd0);
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("b2b_second_lat", 32'(n), 32'd12);
    check("b2b_second_h", 32'(h_out), 32'h30);
    check("b2b_second_y", 32'(y_out), 32'h0);
    tick();

    // writes and start pulses while busy are ignored
    run(8'h00, 1000, 3, 1000, lat, bc, dn, hs, ys);
    check("noise_dones", 32'(dn), 32'd1);
    check("noise_lat", 32'(lat), 32'd12);
    check("noise_h", 32'(hs), 32'h0B);
    run(8'h00, 1000, 1000, 1000, lat, bc, dn, hs, ys);
    check("after_noise_w0_h", 32'(hs), 32'h0B);
    check("after_noise_y", 32'(ys), 32'h8);

    // ena low for 5 cycles during L1
    run(8'h00, 3, 1000, 1000, lat, bc, dn, hs, ys);
    check("ena_lat", 32'(lat), 32'd17);
    check("ena_busy_cycles", 32'(bc), 32'd17);
    check("ena_dones", 32'(dn), 32'd1);
    check("ena_h", 32'(hs), 32'h0B);
    check("ena_y", 32'(ys), 32'h8);

    // reset pulse during L2 aborts with no done
    run(8'h00, 1000, 1000, 10, lat, bc, dn, hs, ys);
    check("rst_dones", 32'(dn), 32'd0);
    check("rst_busy_cycles", 32'(bc), 32'd10);
    run(8'h00, 1000, 1000, 1000, lat, bc, dn, hs, ys);
    check("after_rst_lat", 32'(lat), 32'd12);
    check("after_rst_y", 32'(ys), 32'h8);

    // write with ena=0 must not land
    ena = 1'b0; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'hFF;
    tick();
    ena = 1'b1; wr_en = 1'b0;
    run(8'h00, 1000, 1000, 1000, lat, bc, dn, hs, ys);
    check("ena0_write_h", 32'(hs), 32'h0B);

    // zero layer-1 weights, out-of-range write, then w8 written on the start edge
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = 8'h00;
      tick();
    end
    wr_addr = 4'd12; wr_data = 8'hFF;
    tick();
    wr_addr = 4'd8; wr_data = 8'hFF;
    run(8'h00, 1000, 1000, 1000, lat, bc, dn, hs, ys);
    check("wr_lat", 32'(lat), 32'd12);
    check("wr_h", 32'(hs), 32'hFF);
    check("wr_y", 32'(ys), 32'h5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bnn_layer_sequencer.md
BNN_LAYER_SEQUENCER -- requirements
Module: bnn_layer_sequencer

Interface
REQ-001 Parameter THRESH, default 6: neuron fires when popcount >= THRESH.
REQ-002 Parameter N_L1, default 8: layer-1 neuron count; N_L2, default 4: layer-2 neuron count.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ena  input  1  global enable; low freezes all state.
REQ-006 start  input  1  request one inference; sampled on rising edge.
REQ-007 x_in  input  8  input vector; latched on accepted start.
REQ-008 wr_en  input  1  weight write strobe.
REQ-009 wr_addr  input  4  neuron index 0..11; 0..7 are layer 1, 8..11 are layer 2.
REQ-010 wr_data  input  8  8-bit weight for the addressed neuron.
REQ-011 wr_ready  output  1  combinational ~busy.
REQ-012 busy  output  1  registered; high while an inference is in progress.
REQ-013 done  output  1  registered one-cycle pulse when y_out updates.
REQ-014 y_out  output  4  registered layer-2 result; held until the next done.
REQ-015 h_out  output  8  registered layer-1 activations (debug).

Function
REQ-016 Shall contain 12x8-bit weight registers and one shared XNOR-popcount/threshold unit, time-multiplexed over all neurons; the unit evaluates one neuron per cycle.
REQ-017 Neuron n result shall be (popcount(a XNOR w[n]) >= THRESH), using a 4-bit popcount (range 0..8). For layer 1, a = x latched; for layer 2, a = h.
REQ-018 FSM states shall be IDLE, L1, L2; a 4-bit index idx sequences neurons.
REQ-019 IDLE: on an edge with ena=1 and start=1, latch x_in, set idx=0, set busy=1, and go to L1.
REQ-020 L1: each enabled edge writes h[idx] and increments idx. On the edge where idx=N_L1-1, set idx=0 and go to L2.
REQ-021 L2: each enabled edge writes y[idx]. On the edge where idx=N_L2-1: update y_out, pulse done=1, set busy=0, and go to IDLE.
REQ-022 Latency: done shall be high in the cycle after the 12th enabled edge following the start-accept edge.
REQ-023 start while busy shall be ignored, with no queuing.
REQ-024 start in the done cycle shall be accepted, giving back-to-back inferences.
REQ-025 wr_en with ena=1 and busy=0 shall write w[wr_addr] <= wr_data on that edge.
REQ-026 wr_en while busy=1 shall be ignored. wr_addr 12..15 shall be ignored.
REQ-027 Simultaneous wr_en and start in IDLE shall both take effect; that inference uses the new weight.
REQ-028 ena=0 shall hold state, idx, h, y_out, and weights. done shall be forced to 0 during ena=0 and shall not repeat after ena returns.
REQ-029 h_out shall reflect the h register continuously.

Reset
REQ-030 rst_n low shall, asynchronously, set state=IDLE, idx=0, busy=0, done=0, y_out=0, h=0, and latched x=0.
REQ-031 Weights shall reset to: w0..w7 = A0,41,7A,18,ED,B7,67,3A; w8..w11 = F9,62,F7,0F (hex).
REQ-032 Reset asserted mid-inference shall abort the inference with no done pulse; operation resumes normally after release.

Verification
REQ-033 Reset defaults, start with x_in=0x00 -> done 12 cycles later; h_out=0x0B, y_out=0x8.
REQ-034 Reset defaults, x_in=0xFF -> h_out=0x30, y_out=0x0. busy is high for exactly 12 cycles.
REQ-035 Write w0..w7=0x00 and w8=0xFF (busy=0), then start with x_in=0x00 -> h_out=0xFF, y_out=0x5.
REQ-036 Assert wr_en (w0=0xFF) and repeated start pulses during an inference -> both ignored: a single done occurs, and w0 is unchanged in the next run.
REQ-037 Drop ena for 5 cycles mid-L1 -> done is delayed by exactly 5 cycles, and the result is identical to REQ-033.
REQ-038 Pulse rst_n low mid-L2 -> busy=0 and y_out=0 immediately, with no done. Then start with x_in=0x00 -> y_out=0x8.
